// File: rtl/mac_frame_sched_pkg.sv
// ---------------------------------------------------------------------------
// mac_frame_sched_pkg
//   Shared definitions for the frame-based multiply-accumulate scheduler:
//   the FSM state encoding, the default frame length and accumulator width,
//   the derived result byte count, and a small index-width helper.
// ---------------------------------------------------------------------------
package mac_frame_sched_pkg;

  // Frame sequencing: wait for start, accumulate operand pairs, then
  // serialize the result byte by byte.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  localparam int DEF_COUNT = 8;              // operand pairs per frame
  localparam int DEF_ACC_W = 32;             // accumulator width in bits
  localparam int BYTES     = DEF_ACC_W / 8;  // result bytes for the default width

  // Width of a counter that indexes n items; at least one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mac_frame_sched_acc.sv
// ---------------------------------------------------------------------------
// mac_acc_unit
//   Unsigned 8x8 multiply-accumulate datapath.
//
//   Ports
//     clk, rst_n : clock, asynchronous active-low reset
//     clear      : zero the accumulator on the next edge (wins over enable)
//     enable     : add op_a*op_b to the accumulator on the next edge
//     op_a, op_b : unsigned 8-bit operands
//     acc        : look-ahead sum, i.e. the stored accumulator plus the
//                  product of the pair being added this cycle (when enable
//                  is high). This is exactly the value the register takes
//                  on the next edge, so the scheduler can latch a frame's
//                  final sum in the same cycle as the last accept.
// ---------------------------------------------------------------------------
module mac_acc_unit
  import mac_frame_sched_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [7:0]       op_a,
  input  logic [7:0]       op_b,
  output logic [ACC_W-1:0] acc
);

  logic [15:0]      product;
  logic [ACC_W-1:0] acc_q;

  assign product = 16'(op_a) * 16'(op_b);

  // Product is zero-extended (or truncated for narrow builds); the sum wraps
  // modulo 2^ACC_W.
  assign acc = acc_q + ACC_W'(enable ? product : 16'd0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (clear) begin
      acc_q <= '0;
    end else if (enable) begin
      acc_q <= acc;
    end
  end

endmodule

// File: rtl/mac_frame_sched.sv
// ---------------------------------------------------------------------------
// mac_frame_sched
//   Frame scheduler around a multiply-accumulate unit. A start request opens
//   a frame, COUNT operand pairs are accepted over a valid/ready handshake and
//   their products summed, then the ACC_W-bit sum is streamed out MSB byte
//   first over a second valid/ready handshake. done pulses for one cycle
//   after the last byte is taken.
//
//   Parameters
//     COUNT : operand pairs per frame (1..255)
//     ACC_W : accumulator width in bits (multiple of 8)
//
//   Ports
//     clk, rst_n          : clock, asynchronous active-low reset
//     ena                 : global enable; low freezes the block and blocks
//                           both handshakes
//     start               : open a frame (honoured in IDLE only)
//     abort               : cancel the current frame (beats start)
//     in_valid / in_ready : operand pair handshake, op_a / op_b
//     out_valid/out_ready : result byte handshake, out_byte
//     busy                : frame in progress (ACC or DRAIN)
//     done                : one-cycle pulse after the final byte is accepted
// ---------------------------------------------------------------------------
module mac_frame_sched
  import mac_frame_sched_pkg::*;
#(
  parameter int COUNT = DEF_COUNT,
  parameter int ACC_W = DEF_ACC_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic       abort,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] op_a,
  input  logic [7:0] op_b,
  output logic [7:0] out_byte,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       done
);

  localparam int                N_BYTES  = ACC_W / 8;
  localparam int                IDX_W    = idx_width(N_BYTES);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_BYTES - 1);
  localparam logic [7:0]        LAST_CNT = 8'(COUNT - 1);

  state_t           state;
  logic [7:0]       cnt;        // pairs accepted in this frame
  logic [ACC_W-1:0] result;     // final sum, frozen for the drain phase
  logic [IDX_W-1:0] byte_idx;   // byte of result currently presented
  logic             done_q;

  logic             in_fire;
  logic             out_fire;
  logic             acc_clear;
  logic             acc_en;
  logic [ACC_W-1:0] acc_sum;

  // Handshake readiness comes straight from the registered state, gated by
  // ena so that a frozen block can never complete a transfer.
  assign in_ready  = ena && (state == ST_ACC);
  assign out_valid = ena && (state == ST_DRAIN);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  // A new frame starts from zero; an aborted frame also drops its partial
  // sum so nothing lingers in the datapath.
  assign acc_clear = ena && (abort || ((state == ST_IDLE) && start));
  assign acc_en    = in_fire && !abort;

  mac_acc_unit #(
    .ACC_W (ACC_W)
  ) u_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (acc_clear),
    .enable (acc_en),
    .op_a   (op_a),
    .op_b   (op_b),
    .acc    (acc_sum)
  );

  assign busy     = (state != ST_IDLE);
  assign done     = done_q;
  assign out_byte = result[{byte_idx, 3'b000} +: 8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      result   <= '0;
      byte_idx <= LAST_IDX;
      done_q   <= 1'b0;
    end else begin
      // done is a pulse: it drops after one cycle even if ena falls, so a
      // consumer never sees it stretched.
      done_q <= 1'b0;
      if (ena) begin
        if (abort) begin
          state    <= ST_IDLE;
          cnt      <= '0;
          byte_idx <= LAST_IDX;
        end else begin
          case (state)
            ST_IDLE: begin
              if (start) begin
                cnt      <= '0;
                byte_idx <= LAST_IDX;
                state    <= ST_ACC;
              end
            end

            ST_ACC: begin
              if (in_fire) begin
                cnt <= cnt + 8'd1;
                // acc_sum already includes this pair, so the result is
                // ready for the first drain cycle.
                if (cnt == LAST_CNT) begin
                  result <= acc_sum;
                  state  <= ST_DRAIN;
                end
              end
            end

            ST_DRAIN: begin
              if (out_fire) begin
                if (byte_idx == '0) begin
                  byte_idx <= LAST_IDX;
                  state    <= ST_IDLE;
                  done_q   <= 1'b1;
                end else begin
                  byte_idx <= byte_idx - IDX_W'(1);
                end
              end
            end

            default: state <= ST_IDLE;
          endcase
        end
      end
    end
  end

endmodule

// File: tb/tb_mac_frame_sched.sv
module tb_mac_frame_sched;

  localparam int COUNT = 8;
  localparam int ACC_W = 32;
  localparam int NB    = ACC_W / 8;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       start;
  logic       abort;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;

  int total = 0;
  int bad   = 0;

  // operand pairs of the frame currently being driven
  logic [7:0] pa [COUNT];
  logic [7:0] pb [COUNT];

  typedef struct {
    string       name;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [6];

  always #5 clk = ~clk;

  mac_frame_sched #(
    .COUNT (COUNT),
    .ACC_W (ACC_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .start     (start),
    .abort     (abort),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_byte  (out_byte),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .done      (done)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: the frame result is the plain sum of all products, wrapped
  // to the accumulator width.
  function automatic logic [ACC_W-1:0] model_sum();
    longint s = 0;
    for (int i = 0; i < COUNT; i++) s += longint'(pa[i]) * longint'(pb[i]);
    return ACC_W'(s);
  endfunction

  task automatic fill_const(input logic [7:0] a, input logic [7:0] b);
    for (int i = 0; i < COUNT; i++) begin
      pa[i] = a;
      pb[i] = b;
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < COUNT; i++) begin
      pa[i] = 8'($urandom);
      pb[i] = 8'($urandom);
    end
  endtask

  // Drives one full frame from pa/pb and collects the output bytes.
  //   vmode: 0 continuous in_valid, 1 every other cycle, 2 random
  //   rmode: 0 out_ready high, 1 three stall cycles on the second byte out,
  //          2 random
  //   gaps : five ena-low cycles mid-ACC and five mid-DRAIN
  task automatic run_frame(input string tag, input int vmode, input int rmode,
                           input bit gaps, input logic [ACC_W-1:0] exp);
    int pi = 0, nbytes = 0, ndone = 0, cyc = 0, gap_left = 0;
    int stall = 0, proto = 0, unstable = 0;
    bit g1 = 0, g2 = 0, last_acc = 0, prev_hold = 0;
    logic [7:0] prev_byte = '0;
    logic [ACC_W-1:0] got = '0;

    ena = 1'b1; in_valid = 1'b0; out_ready = 1'b0; abort = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;

    while (ndone == 0 && cyc < 1000) begin
      if (gaps && pi == 4 && !g1) begin g1 = 1; gap_left = 5; end
      if (gaps && nbytes == 2 && !g2) begin g2 = 1; gap_left = 5; end
      ena = (gap_left == 0);
      if (gap_left > 0) gap_left--;

      if (pi >= COUNT) in_valid = 1'b1;  // extra pairs must be refused
      else begin
        case (vmode)
          0:       in_valid = 1'b1;
          1:       in_valid = (cyc % 2 == 0);
          default: in_valid = ($urandom_range(99) < 60);
        endcase
      end
      if (pi < COUNT) begin op_a = pa[pi]; op_b = pb[pi]; end
      else begin op_a = 8'($urandom); op_b = 8'($urandom); end

      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = !(nbytes == 1 && stall < 3);
        default: out_ready = ($urandom_range(99) < 50);
      endcase

      #4;  // mid-cycle sample
      if (!ena && (in_ready || out_valid)) proto++;
      if (pi >= COUNT && in_ready) proto++;
      if (pi < COUNT && out_valid) proto++;
      if (!busy) proto++;
      if (last_acc && ena) begin
        if (!out_valid) proto++;
        last_acc = 0;
      end
      if (prev_hold && out_byte !== prev_byte) unstable++;
      prev_hold = out_valid && !out_ready;
      prev_byte = out_byte;
      if (rmode == 1 && nbytes == 1 && out_valid && !out_ready) stall++;
      if (in_valid && in_ready) begin
        pi++;
        if (pi == COUNT) last_acc = 1;
      end
      if (out_valid && out_ready) begin
        got = {got[ACC_W-9:0], out_byte};
        nbytes++;
      end

      step();
      cyc++;
      if (done) begin
        ndone++;
        if (nbytes != NB) proto++;
      end
    end

    in_valid = 1'b0; out_ready = 1'b0; ena = 1'b1;
    check({tag, " sum"}, got, exp);
    check({tag, " byte count"}, nbytes, NB);
    check({tag, " done seen"}, ndone, 1);
    check({tag, " protocol"}, proto, 0);
    check({tag, " byte stable"}, unstable, 0);
    if (rmode == 1) check({tag, " stall cycles"}, stall, 3);
    step();
    check({tag, " done width"}, done, 1'b0);
    check({tag, " idle after"}, busy, 1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd;
    tbl[0] = '{"ones",     8'd1,   8'd1,   32'h0000_0008};
    tbl[1] = '{"max",      8'd255, 8'd255, 32'h0007_F008};
    tbl[2] = '{"2x3",      8'd2,   8'd3,   32'h0000_0030};
    tbl[3] = '{"zero",     8'd0,   8'd200, 32'h0000_0000};
    tbl[4] = '{"16x16",    8'd16,  8'd16,  32'h0000_0800};
    tbl[5] = '{"128x2",    8'd128, 8'd2,   32'h0000_0800};

    rst_n = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0; op_a = '0; op_b = '0;

    // reset values
    #3;
    check("rst in_ready", in_ready, 1'b0);
    check("rst out_valid", out_valid, 1'b0);
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst out_byte", out_byte, 8'h00);
    #9 rst_n = 1'b1;
    step();

    // IDLE refuses pairs and presents nothing
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    check("idle in_ready", in_ready, 1'b0);
    check("idle out_valid", out_valid, 1'b0);
    in_valid = 1'b0; out_ready = 1'b0;

    // start with abort acts as abort
    start = 1'b1; abort = 1'b1;
    step();
    start = 1'b0; abort = 1'b0;
    check("start+abort idle", busy, 1'b0);

    // constant-operand frames
    foreach (tbl[i]) begin
      fill_const(tbl[i].a, tbl[i].b);
      run_frame(tbl[i].name, 0, 0, 1'b0, ACC_W'(tbl[i].exp));
    end

    // alternating in_valid, three stall cycles on byte 2
    fill_const(8'd255, 8'd255);
    run_frame("toggle+stall", 1, 1, 1'b0, 32'h0007_F008);

    // abort after four pairs
    ena = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    check("abort busy in frame", busy, 1'b1);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; op_a = 8'd9; op_b = 8'd9;
      step();
    end
    in_valid = 1'b0; abort = 1'b1;
    step();
    abort = 1'b0;
    check("abort to idle", busy, 1'b0);
    nd = 0;
    for (int k = 0; k < 3; k++) begin
      if (done) nd++;
      step();
    end
    check("abort no done", nd, 0);
    fill_const(8'd2, 8'd3);
    run_frame("after abort", 0, 0, 1'b0, 32'h0000_0030);

    // ena gaps: same result as an ena-high run of the same operands
    fill_random();
    run_frame("ena high", 0, 0, 1'b0, model_sum());
    run_frame("ena gaps", 0, 0, 1'b1, model_sum());

    // randomized frames against the reference
    for (int f = 0; f < 20; f++) begin
      fill_random();
      if (f == 0) fill_const(8'd255, 8'd255);
      run_frame($sformatf("rand%0d", f), 2, 2, (f % 4 == 3), model_sum());
    end

    // asynchronous reset in the middle of DRAIN
    fill_const(8'd1, 8'd1);
    ena = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1; op_a = 8'd1; op_b = 8'd1;
    for (int k = 0; k < COUNT; k++) step();
    in_valid = 1'b0;
    check("pre-reset out_valid", out_valid, 1'b1);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check("mid-drain rst out_valid", out_valid, 1'b0);
    check("mid-drain rst in_ready", in_ready, 1'b0);
    check("mid-drain rst busy", busy, 1'b0);
    check("mid-drain rst done", done, 1'b0);
    check("mid-drain rst out_byte", out_byte, 8'h00);
    #2 rst_n = 1'b1;
    step();
    step();
    check("post-reset idle", busy, 1'b0);
    run_frame("post reset", 0, 0, 1'b0, 32'h0000_0008);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mac_frame_sched.md
MAC_FRAME_SCHED -- requirements
Module: mac_frame_sched

Interface
REQ-001 SHALL have parameter COUNT, default 8, meaning operand pairs per frame; legal range 1..255.
REQ-002 SHALL have parameter ACC_W, default 32, meaning accumulator width in bits.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port ena  input  1  global enable; low freezes all state.
REQ-006 SHALL have port start  input  1  frame start request, sampled in IDLE only.
REQ-007 SHALL have port abort  input  1  cancels the current frame from any state.
REQ-008 SHALL have port in_valid  input  1  operand pair present.
REQ-009 SHALL have port in_ready  output  1  block accepts an operand pair this cycle.
REQ-010 SHALL have port op_a  input  8  unsigned operand A.
REQ-011 SHALL have port op_b  input  8  unsigned operand B.
REQ-012 SHALL have port out_byte  output  8  current result byte.
REQ-013 SHALL have port out_valid  output  1  out_byte is valid.
REQ-014 SHALL have port out_ready  input  1  consumer accepts out_byte.
REQ-015 SHALL have port busy  output  1  high in ACC or DRAIN.
REQ-016 SHALL have port done  output  1  one-cycle pulse after the last result byte is accepted.

Function
REQ-017 SHALL implement states IDLE, ACC, DRAIN.
REQ-018 IDLE: start=1 with ena=1 SHALL clear accumulator and pair counter, then enter ACC on the next cycle.
REQ-019 ACC: in_ready SHALL be 1 when ena=1; each cycle with in_valid&in_ready SHALL add op_a*op_b (16-bit unsigned, zero-extended) to the accumulator and increment the pair counter.
REQ-020 ACC: the accept that brings the pair counter to COUNT SHALL move the block to DRAIN on the next cycle, with the final sum latched into the result register; no further pairs SHALL be accepted.
REQ-021 ACC: a cycle with in_valid=0 SHALL leave the accumulator and counter unchanged, with no timeout.
REQ-022 Arithmetic SHALL be modulo 2^ACC_W; with COUNT<=255 and ACC_W=32, overflow cannot occur.
REQ-023 DRAIN: out_valid SHALL be 1 when ena=1; out_byte SHALL present result bytes MSB first, from [ACC_W-1:ACC_W-8] down to [7:0].
REQ-024 DRAIN: out_byte SHALL be stable while out_valid=1 and out_ready=0.
REQ-025 DRAIN: each out_valid&out_ready SHALL advance to the next byte.
REQ-026 DRAIN: acceptance of byte 0 SHALL return the block to IDLE and assert done for exactly one cycle.
REQ-027 start SHALL be ignored outside IDLE; start and abort asserted together SHALL act as abort.
REQ-028 abort=1 SHALL force IDLE on the next edge from any state, clear counter and byte index, and suppress done.
REQ-029 ena=0 SHALL hold all registers, and SHALL force in_ready=0 and out_valid=0 so that no handshake completes.
REQ-030 in_ready SHALL be 0 in IDLE and DRAIN; out_valid SHALL be 0 in IDLE and ACC.
REQ-031 Accept-to-first-out_valid latency SHALL be exactly 1 cycle after the COUNT-th accept.

Reset
REQ-032 rst_n low SHALL asynchronously force state=IDLE, accumulator=0, result=0, counter=0, byte index=ACC_W/8-1.
REQ-033 During reset, in_ready, out_valid, busy and done SHALL be 0, and out_byte SHALL be 0x00.
REQ-034 Reset deassertion mid-frame SHALL leave the block in IDLE awaiting start.

Structure
REQ-035 A shared package SHALL hold the state enum (IDLE/ACC/DRAIN), the COUNT and ACC_W defaults, and the derived BYTES=ACC_W/8 constant.
REQ-036 The multiply-accumulate datapath SHALL be a sub-module mac_acc_unit (clear, enable, op_a, op_b, acc out); mac_frame_sched SHALL contain the FSM, counters and serializer.

Verification
REQ-037 COUNT=8, eight pairs 1x1 with in_valid continuous, out_ready=1 -> bytes 00,00,00,08, then done pulse.
REQ-038 COUNT=8, eight pairs 255x255 -> bytes 00,07,F0,08 (0x0007F008).
REQ-039 in_valid toggling every other cycle, and out_ready low for 3 cycles on byte 2 -> same sum, byte 2 held stable, no duplicate or lost bytes.
REQ-040 abort asserted after 4 pairs, then a new frame of 8 pairs 2x3 -> bytes 00,00,00,30 (no carry-over from the aborted frame), no done on the aborted frame.
REQ-041 ena low for 5 cycles mid-ACC and mid-DRAIN -> in_ready and out_valid 0 during those cycles, and the final result is identical to the ena-high run.
REQ-042 rst_n pulsed low asynchronously mid-DRAIN -> outputs immediately at reset values; start then gives a clean frame.
